ireg_skew_line: RTL and testbench

IREG_SKEW_LINE -- requirements
Module: ireg_skew_line

---
 rtl/ireg_skew_pkg.sv | 10 +
 rtl/ireg_skew_line_if.sv | 16 +
 rtl/ireg_skew_line_stage.sv | 35 +++
 rtl/ireg_skew_line.sv | 60 ++++++
 tb/tb_ireg_skew_line.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ireg_skew_pkg.sv
// ireg_skew_pkg: default geometry for the skew line and the per-channel stage count.
package ireg_skew_pkg;
    localparam int CH_DEF    = 4;
    localparam int WIDTH_DEF = 16;
    localparam int STEP_DEF  = 1;

    function automatic int stages(input int c, input int step);
        return c * step + 1;
    endfunction
endpackage

// File: rtl/ireg_skew_line_if.sv
// ireg_skew_line_if: token input and skewed output bundle of the skew line.
interface ireg_skew_line_if import ireg_skew_pkg::*; #(
    parameter int CH    = CH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
);
    localparam int IW = $clog2((CH - 1) * STEP + 3);
    logic                       i_valid;
    logic [CH-1:0][WIDTH-1:0]   i_data;
    logic [CH-1:0]              o_valid;
    logic [CH-1:0][WIDTH-1:0]   o_data;
    logic                       o_busy;
    logic [IW-1:0]              o_inflight;
    modport master (output i_valid, i_data, input o_valid, o_data, o_busy, o_inflight);
    modport slave  (input i_valid, i_data, output o_valid, o_data, o_busy, o_inflight);
endinterface

// File: rtl/ireg_skew_line_stage.sv
// ireg_stage: one pipeline stage (valid + data) with clr > en > hold priority.
module ireg_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);
    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Data only loads behind a valid token so idle cycles do not disturb it.
    always_comb begin
        v_d = clr ? 1'b0 : en ? v_i : v_q;
        d_d = clr ? '0 : (en && v_i) ? d_i : d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;
endmodule

// File: rtl/ireg_skew_line.sv
// ireg_skew_line: per-channel delay chains of c*STEP+1 stages feeding a systolic array.
// Optional channel CH-1 token counter enabled by macro IREG_SKEW_INFLIGHT_EN.
module ireg_skew_line import ireg_skew_pkg::*; #(
    parameter int CH    = CH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    ireg_skew_line_if.slave   bus
);
    logic [CH-1:0]            ov, ch_busy;
    logic [CH-1:0][WIDTH-1:0] od;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam int N = stages(c, STEP);
        logic [N:0]            v;
        logic [N:0][WIDTH-1:0] d;
        assign v[0] = bus.i_valid;
        assign d[0] = bus.i_data[c];
        for (genvar s = 0; s < N; s++) begin : g_st
            ireg_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .clr   (clr),
                .v_i   (v[s]),
                .d_i   (d[s]),
                .v_o   (v[s+1]),
                .d_o   (d[s+1])
            );
        end
        assign ov[c]      = v[N];
        assign od[c]      = d[N];
        assign ch_busy[c] = |v[N:1];
    end

    assign bus.o_valid = ov;
    assign bus.o_data  = od;
    assign bus.o_busy  = |ch_busy;

`ifdef IREG_SKEW_INFLIGHT_EN
    localparam int IW = $clog2((CH - 1) * STEP + 3);
    logic [IW-1:0] cnt_q, cnt_d;

    // Entry and exit in the same advance cancel out.
    always_comb cnt_d = clr ? '0 : !en ? cnt_q : cnt_q + IW'(bus.i_valid) - IW'(ov[CH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.o_inflight = cnt_q;
`else
    assign bus.o_inflight = '0;
`endif
endmodule

// File: tb/tb_ireg_skew_line.sv
// tb_ireg_skew_line: directed checks of reset, latency, stall, clear and inflight counting.
module tb_ireg_skew_line;
    localparam int CH = 4, WIDTH = 16, STEP = 1;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
    int   errors = 0, checks = 0;

    ireg_skew_line_if #(.CH(CH), .WIDTH(WIDTH), .STEP(STEP)) bus ();

    ireg_skew_line #(.CH(CH), .WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] w);
        bus.i_valid = v;
        for (int c = 0; c < CH; c++) bus.i_data[c] = w;
    endtask

    task automatic drain();
        drive(1'b0, '0);
        en = 1'b1;
        clr = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        drive(1'b0, '0);
        en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b1, 16'h5A5A);
        tick();
        tick();
        drive(1'b0, '0);
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy got=%b exp=1", bus.o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== '0 || bus.o_data !== '0 || bus.o_busy !== 1'b0 || bus.o_inflight !== '0) begin
            errors++;
            $display("FAIL reset_async got v=%b d=%h busy=%b inf=%0d exp all zero",
                     bus.o_valid, bus.o_data, bus.o_busy, bus.o_inflight);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.o_valid !== '0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got v=%b busy=%b exp 0/0", bus.o_valid, bus.o_busy);
        end
    endtask

    task automatic test_single();
        logic [CH-1:0] exp_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        en = 1'b1;
        drive(1'b1, 16'h00A5);
        for (int e = 0; e < 5; e++) begin
            tick();
            drive(1'b0, '0);
            checks++;
            if (bus.o_valid !== exp_v[e] || bus.o_busy !== (e < 4)) begin
                errors++;
                $display("FAIL single_e%0d got v=%b busy=%b exp v=%b busy=%b",
                         e + 1, bus.o_valid, bus.o_busy, exp_v[e], e < 4);
            end
        end
        checks++;
        if (bus.o_data[0] !== 16'h00A5 || bus.o_data[3] !== 16'h00A5) begin
            errors++;
            $display("FAIL single_data got d0=%h d3=%h exp 00a5", bus.o_data[0], bus.o_data[3]);
        end
    endtask

    task automatic test_stall();
        logic [CH-1:0] exp_v [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        drive(1'b1, 16'h00A5);
        for (int e = 0; e < 7; e++) begin
            en = !(e == 2 || e == 3);
            tick();
            drive(1'b0, '0);
            checks++;
            if (bus.o_valid !== exp_v[e]) begin
                errors++;
                $display("FAIL stall_e%0d got v=%b exp v=%b", e + 1, bus.o_valid, exp_v[e]);
            end
        end
        checks++;
        if (bus.o_data[3] !== 16'h00A5) begin
            errors++;
            $display("FAIL stall_data got=%h exp=00a5", bus.o_data[3]);
        end
        en = 1'b1;
    endtask

    task automatic test_clear();
        en = 1'b1;
        drive(1'b1, 16'h00A5);
        tick();
        drive(1'b0, '0);
        tick();
        clr = 1'b1;
        drive(1'b1, 16'h1234);
        tick();
        clr = 1'b0;
        drive(1'b0, '0);
        checks++;
        if (bus.o_valid !== '0 || bus.o_data !== '0 || bus.o_busy !== 1'b0 || bus.o_inflight !== '0) begin
            errors++;
            $display("FAIL clear_now got v=%b d=%h busy=%b inf=%0d exp all zero",
                     bus.o_valid, bus.o_data, bus.o_busy, bus.o_inflight);
        end
        for (int e = 0; e < 4; e++) begin
            tick();
            checks++;
            if (bus.o_valid !== '0 || bus.o_data !== '0) begin
                errors++;
                $display("FAIL clear_after_e%0d got v=%b d=%h exp zero", e, bus.o_valid, bus.o_data);
            end
        end
        drive(1'b1, 16'h0077);
        tick();
        drive(1'b0, '0);
        en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_data !== '0) begin
            errors++;
            $display("FAIL clear_en0 got busy=%b d=%h exp zero", bus.o_busy, bus.o_data);
        end
    endtask

    task automatic test_back_to_back();
`ifdef IREG_SKEW_INFLIGHT_EN
        int exp_inf [10] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0};
`else
        int exp_inf [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        logic exp_v3;
        en = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            drive(e <= 6, (e <= 6) ? 16'(e) : 16'h0000);
            tick();
            exp_v3 = (e >= 4 && e <= 9);
            checks++;
            if (bus.o_inflight !== 3'(exp_inf[e-1])) begin
                errors++;
                $display("FAIL inflight_e%0d got=%0d exp=%0d", e, bus.o_inflight, exp_inf[e-1]);
            end
            checks++;
            if (bus.o_valid[3] !== exp_v3 || bus.o_valid[0] !== (e <= 6)) begin
                errors++;
                $display("FAIL b2b_valid_e%0d got v=%b exp v3=%b v0=%b", e, bus.o_valid, exp_v3, e <= 6);
            end
            if (exp_v3) begin
                checks++;
                if (bus.o_data[3] !== 16'(e - 3)) begin
                    errors++;
                    $display("FAIL b2b_data_e%0d got=%h exp=%h", e, bus.o_data[3], 16'(e - 3));
                end
            end
        end
        drive(1'b0, '0);
    endtask

    initial begin
        drive(1'b0, '0);
        test_reset();
        test_single();
        drain();
        test_stall();
        drain();
        test_clear();
        drain();
        test_back_to_back();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
